// File: rtl/mips_pkg.sv
// mips_pkg: shared bus widths, ls_op encodings and EXE->MEM / MEM->WB field offsets.
package mips_pkg;
  localparam int EXE_MEM_W = 159;
  localparam int MEM_WB_W  = 124;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} ls_size_e;
  localparam int LS_UNS   = 154;
  localparam int LS_SIZE  = 155;
  localparam int LS_STORE = 157;
  localparam int LS_LOAD  = 158;
  localparam int EM_WDEST = 32;
  localparam int EM_WEN   = 37;
  localparam int EM_EXC   = 38;
  localparam int EM_CP0   = 44;
  localparam int EM_CTRL  = 52;
  localparam int EM_LO    = 58;
  localparam int EM_RES   = 90;
  localparam int EM_SD    = 122;
  localparam int MW_PC    = 0;
  localparam int MW_OVF   = 32;
  localparam int MW_WAERR = 33;
  localparam int MW_RAERR = 34;
  localparam int MW_EXC   = 35;
  localparam int MW_CP0   = 40;
  localparam int MW_CTRL  = 48;
  localparam int MW_LO    = 54;
  localparam int MW_RES   = 86;
  localparam int MW_WDEST = 118;
  localparam int MW_WEN   = 123;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    return (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: byte enables and store replication for writes, lane extract and extension for loads.
module mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  ls_size_e   sz;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sz = ls_size_e'(size_i);
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o = sz == SZ_BYTE ? 4'b0001 << addr_i : sz == SZ_HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = sz == SZ_BYTE ? {4{store_data_i[7:0]}} : sz == SZ_HALF ? {2{store_data_i[15:0]}} : store_data_i;
    ldata_o = sz == SZ_BYTE ? {{24{b[7] & !uns_i}}, b} : sz == SZ_HALF ? {{16{h[15] & !uns_i}}, h} : rdata_i;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage; latches EXE->MEM, drives the sync data RAM, builds MEM->WB.
module mem_stage
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 EXE_over,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
  input  logic                 WB_allow_in,
  input  logic                 cancel,
  output logic                 MEM_allow_in,
  output logic                 MEM_valid,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic                 dm_en,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata
);
  logic [EXE_MEM_W-1:0] bus_q, bus_d;
  logic [MEM_WB_W-1:0]  wb;
  logic        valid_q, valid_d, ld_phase_q, ld_phase_d, ld_hold_q, ld_hold_d, st_done_q, st_done_d;
  logic [31:0] ld_data_q, ld_data_d, res, wdata, ldata, rdata;
  logic [3:0]  be;
  logic        load, store, raddr_error, waddr_error, exc_in, ld_acc, clr;
  assign res   = bus_q[EM_RES +: 32];
  assign load  = bus_q[LS_LOAD];
  assign store = bus_q[LS_STORE];
  assign raddr_error = load & misaligned(bus_q[LS_SIZE +: 2], res[1:0]);
  assign waddr_error = store & misaligned(bus_q[LS_SIZE +: 2], res[1:0]);
  // Read data is only valid the cycle after dm_en; keep a copy for WB stalls.
  assign rdata = ld_hold_q ? ld_data_q : dm_rdata;
  mem_align u_align (
    .size_i      (bus_q[LS_SIZE +: 2]),
    .uns_i       (bus_q[LS_UNS]),
    .addr_i      (res[1:0]),
    .store_data_i(bus_q[EM_SD +: 32]),
    .rdata_i     (rdata),
    .be_o        (be),
    .wdata_o     (wdata),
    .ldata_o     (ldata)
  );
  always_comb begin
    exc_in = |bus_q[EM_EXC +: 6] | raddr_error | waddr_error;
    ld_acc = load & !exc_in;
    MEM_valid = valid_q;
    MEM_over = valid_q & (!ld_acc | ld_phase_q);
    MEM_allow_in = !valid_q | (MEM_over & WB_allow_in);
    dm_wen = be & {4{valid_q & store & !st_done_q & !exc_in & !cancel}};
    dm_en = (valid_q & ld_acc & !ld_phase_q) | (|dm_wen);
    dm_addr = valid_q ? {res[31:2], 2'b00} : '0;
    dm_wdata = valid_q ? wdata : '0;
    MEM_wdest = bus_q[EM_WDEST +: 5] & {5{valid_q}};
    wb = '0;
    wb[MW_PC +: 32]   = bus_q[31:0];
    wb[MW_OVF]        = bus_q[EM_EXC];
    wb[MW_WAERR]      = waddr_error;
    wb[MW_RAERR]      = raddr_error;
    wb[MW_EXC +: 5]   = bus_q[EM_EXC + 1 +: 5];
    wb[MW_CP0 +: 8]   = bus_q[EM_CP0 +: 8];
    wb[MW_CTRL +: 6]  = bus_q[EM_CTRL +: 6];
    wb[MW_LO +: 32]   = bus_q[EM_LO +: 32];
    wb[MW_RES +: 32]  = ld_acc ? ldata : res;
    wb[MW_WDEST +: 5] = bus_q[EM_WDEST +: 5];
    wb[MW_WEN]        = bus_q[EM_WEN] & !(raddr_error | waddr_error);
    MEM_WB_bus = valid_q ? wb : '0;
    clr = cancel | MEM_allow_in;
    bus_d = EXE_over & MEM_allow_in ? EXE_MEM_bus : bus_q;
    valid_d = cancel ? 1'b0 : MEM_allow_in ? EXE_over : valid_q;
    ld_phase_d = clr ? 1'b0 : ld_phase_q | (valid_q & ld_acc);
    ld_hold_d = clr ? 1'b0 : ld_hold_q | ld_phase_q;
    st_done_d = clr ? 1'b0 : st_done_q | (|dm_wen);
    ld_data_d = ld_phase_q & !ld_hold_q ? dm_rdata : ld_data_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      ld_phase_q <= 1'b0;
      ld_hold_q  <= 1'b0;
      st_done_q  <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      ld_phase_q <= ld_phase_d;
      ld_hold_q  <= ld_hold_d;
      st_done_q  <= st_done_d;
      ld_data_q  <= ld_data_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random stimulus against a transaction-level model of the MEM stage.
module tb_mem_stage;
  logic         clk, resetn, EXE_over, WB_allow_in, cancel;
  logic [158:0] EXE_MEM_bus;
  logic         MEM_allow_in, MEM_valid, MEM_over, dm_en;
  logic [123:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_addr, dm_wdata, dm_rdata;
  int n_checks = 0, n_err = 0;
  mem_stage dut (
    .clk(clk), .resetn(resetn), .EXE_over(EXE_over), .EXE_MEM_bus(EXE_MEM_bus),
    .WB_allow_in(WB_allow_in), .cancel(cancel), .MEM_allow_in(MEM_allow_in),
    .MEM_valid(MEM_valid), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
    .MEM_wdest(MEM_wdest), .dm_en(dm_en), .dm_wen(dm_wen), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] pat(input int i);
    return (32'h1357_9BDF * (i + 1)) ^ 32'hA5A5_0000;
  endfunction
  // Sync RAM; output is garbage on cycles without dm_en, so held load data must come from the stage.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (!resetn) for (int i = 0; i < 16; i++) ram[i] <= pat(i);
    else for (int k = 0; k < 4; k++) if (dm_wen[k]) ram[dm_addr[5:2]][8*k +: 8] <= dm_wdata[8*k +: 8];
    dm_rdata <= dm_en ? ram[dm_addr[5:2]] : $urandom;
  end
  logic         m_valid, m_written;
  logic [158:0] m_b;
  logic [31:0]  m_rd;
  int           m_cyc;
  logic [31:0]  ref_mem [16];
  logic         s_allow, s_valid, s_over, s_en;
  logic [123:0] s_bus;
  logic [4:0]   s_wdest;
  logic [3:0]   s_wen;
  logic [31:0]  s_wdata;
  task automatic chk(input string nm, input logic [123:0] act, input logic [123:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz, input logic un, input logic [1:0] a);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!un && v >= 32768) v = v - 65536;
    end else v = w;
    return v;
  endfunction
  function automatic logic [158:0] mk(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                                      input logic [31:0] sd, input logic [31:0] res, input logic [5:0] fl,
                                      input logic wen, input logic [4:0] wd);
    logic [158:0] b;
    logic [31:0]  r;
    r = $urandom;
    b = '0;
    b[31:0] = $urandom;
    b[89:58] = $urandom;
    b[57:44] = r[13:0];
    b[158] = ld; b[157] = st; b[156:155] = sz; b[154] = un;
    b[153:122] = sd; b[121:90] = res; b[43:38] = fl; b[37] = wen; b[36:32] = wd;
    return b;
  endfunction
  function automatic logic [158:0] rnd_bus();
    int kind;
    logic [5:0] fl;
    kind = $urandom_range(0, 2);
    fl = '0;
    if ($urandom_range(0, 9) == 0) fl[$urandom_range(0, 5)] = 1'b1;
    return mk(kind == 1, kind == 2, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
              kind == 0 ? $urandom : 32'($urandom_range(0, 63)), fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endfunction
  // Samples one cycle against the model, then advances the model across the coming edge.
  task automatic step();
    logic ld, st, un, ra, wa, exc, ld_ok, e_over, e_allow, e_en;
    logic [1:0] sz, a;
    logic [31:0] sd, res, e_res, e_wd, e_addr;
    logic [3:0] e_wen;
    logic [123:0] e_bus;
    int idx;
    #1;
    ld = m_b[158]; st = m_b[157]; sz = m_b[156:155]; un = m_b[154];
    sd = m_b[153:122]; res = m_b[121:90]; a = res[1:0]; idx = int'(res[5:2]);
    ra = ld && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0));
    wa = st && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0));
    exc = (m_b[43:38] != 6'd0) || ra || wa;
    ld_ok = ld && !exc;
    e_over = m_valid && (!ld_ok || m_cyc >= 1);
    e_allow = !m_valid || (e_over && WB_allow_in);
    e_wen = '0;
    if (m_valid && st && !exc && !m_written && !cancel)
      e_wen = sz == 2'd0 ? 4'(1 << a) : sz == 2'd1 ? (a >= 2'd2 ? 4'hC : 4'h3) : 4'hF;
    e_en = (m_valid && ld_ok && m_cyc == 0) || e_wen != 4'd0;
    e_addr = m_valid ? res & 32'hFFFF_FFFC : 32'd0;
    e_wd = !m_valid ? 32'd0 : sz == 2'd0 ? {24'd0, sd[7:0]} * 32'h0101_0101 :
           sz == 2'd1 ? {16'd0, sd[15:0]} * 32'h0001_0001 : sd;
    e_res = ld_ok ? extract(m_rd, sz, un, a) : res;
    e_bus = m_valid ? {m_b[37] && !(ra || wa), m_b[36:32], e_res, m_b[89:58], m_b[57:39], ra, wa, m_b[38], m_b[31:0]} : '0;
    s_allow = MEM_allow_in; s_valid = MEM_valid; s_over = MEM_over; s_en = dm_en;
    s_bus = MEM_WB_bus; s_wdest = MEM_wdest; s_wen = dm_wen; s_wdata = dm_wdata;
    chk("allow_in", s_allow, e_allow);
    chk("valid", s_valid, m_valid);
    chk("over", s_over, e_over);
    chk("wdest", s_wdest, m_valid ? m_b[36:32] : 5'd0);
    chk("dm_en", s_en, e_en);
    chk("dm_wen", s_wen, e_wen);
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_wdata", s_wdata, e_wd);
    if (!m_valid || e_over) chk("wb_bus", s_bus, e_bus);
    if (e_wen != 4'd0) begin
      for (int k = 0; k < 4; k++) if (e_wen[k]) ref_mem[idx][8*k +: 8] = e_wd[8*k +: 8];
      m_written = 1'b1;
    end
    if (m_valid && ld_ok && m_cyc == 0) m_rd = ref_mem[idx];
    if (!resetn || cancel) m_valid = 1'b0;
    else if (e_allow) begin
      m_valid = EXE_over; m_b = EXE_MEM_bus; m_cyc = 0; m_written = 1'b0;
    end else m_cyc++;
    @(negedge clk);
  endtask
  task automatic send(input logic [158:0] b);
    EXE_over = 1'b1;
    EXE_MEM_bus = b;
    step();
    EXE_over = 1'b0;
  endtask
  initial begin
    int nw, ov;
    resetn = 1'b0; EXE_over = 1'b0; WB_allow_in = 1'b1; cancel = 1'b0; EXE_MEM_bus = '0;
    m_valid = 1'b0; m_written = 1'b0; m_b = '0; m_rd = '0; m_cyc = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
    @(negedge clk);
    @(negedge clk);
    step();
    chk("rst_allow", s_allow, 1);
    chk("rst_valid", s_valid, 0);
    chk("rst_bus", s_bus, 0);
    resetn = 1'b1;
    send(mk(0, 1, 2, 0, 32'h8899_AABB, 32'h10, 0, 0, 0));
    step();
    chk("sw_wen", s_wen, 4'hF);
    send(mk(1, 0, 2, 0, 0, 32'h10, 0, 1, 5'd3));
    step();
    chk("lw_en_c0", s_en, 1);
    chk("lw_over_c0", s_over, 0);
    step();
    chk("lw_over_c1", s_over, 1);
    chk("lw_result", s_bus[117:86], 32'h8899_AABB);
    chk("lw_wen", s_bus[123], 1);
    send(mk(0, 1, 2, 0, 32'h8011_2233, 32'h10, 0, 0, 0));
    step();
    send(mk(1, 0, 0, 0, 0, 32'h13, 0, 1, 5'd4));
    step(); step();
    chk("lb_result", s_bus[117:86], 32'hFFFF_FF80);
    send(mk(1, 0, 0, 1, 0, 32'h13, 0, 1, 5'd4));
    step(); step();
    chk("lbu_result", s_bus[117:86], 32'h0000_0080);
    WB_allow_in = 1'b0;
    send(mk(0, 1, 1, 0, 32'h1234_ABCD, 32'h22, 0, 0, 0));
    step();
    chk("sh_wen", s_wen, 4'b1100);
    chk("sh_wdata", s_wdata, 32'hABCD_ABCD);
    nw = 0;
    repeat (3) begin
      step();
      nw += int'(s_wen != 4'd0);
    end
    chk("sh_single_write", nw, 0);
    WB_allow_in = 1'b1;
    step();
    send(mk(1, 0, 2, 0, 0, 32'h06, 0, 1, 5'd7));
    step();
    chk("lw_raddr_err", s_bus[34], 1);
    chk("lw_err_wen", s_bus[123], 0);
    chk("lw_err_result", s_bus[117:86], 32'h6);
    chk("lw_err_en", s_en, 0);
    chk("lw_err_over", s_over, 1);
    send(mk(0, 1, 2, 0, 32'hDEAD_BEEF, 32'h03, 0, 0, 0));
    step();
    chk("sw_waddr_err", s_bus[33], 1);
    chk("sw_err_wen", s_wen, 4'd0);
    send(mk(1, 0, 2, 0, 0, 32'h10, 0, 1, 5'd5));
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step();
    chk("cancel_valid", s_valid, 0);
    chk("cancel_wdest", s_wdest, 0);
    chk("cancel_allow", s_allow, 1);
    EXE_over = 1'b1;
    EXE_MEM_bus = mk(1, 0, 2, 0, 0, 32'h10, 0, 1, 5'd8);
    step();
    EXE_MEM_bus = mk(0, 0, 2, 0, 0, 32'h1234_5678, 0, 1, 5'd9);
    step();
    ov = int'(s_over);
    step();
    chk("b2b_allow_c1", s_allow, 1);
    ov += int'(s_over);
    EXE_over = 1'b0;
    step();
    ov += int'(s_over);
    chk("b2b_pulses", ov, 2);
    chk("b2b_add_wdest", s_wdest, 5'd9);
    repeat (3000) begin
      EXE_over = $urandom_range(0, 9) < 6;
      WB_allow_in = $urandom_range(0, 9) < 7;
      cancel = $urandom_range(0, 19) == 0;
      EXE_MEM_bus = rnd_bus();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
